// File: rtl/i2c_slave_module.sv
// I2C responder: oversampled SCL/SDA, device-address match, 1/2-byte register
// pointer, single-cycle write strobe and 1-cycle-latency read fetch port.
module i2c_slave_module #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5A,
  parameter int         ADDR_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  output logic        o_wr_en,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_rd_en,
  output logic [15:0] o_rd_addr,
  input  logic [7:0]  i_rd_data,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  localparam logic [1:0] NUM_AB = 2'(ADDR_BYTES);

  logic        scl_s1_q, scl_s2_q, scl_d_q;
  logic        sda_s1_q, sda_s2_q, sda_d_q;
  state_t      state_q;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  addr_hi_q;
  logic [1:0]  abyte_q;
  logic [15:0] ptr_q;
  logic        rw_q, cap_q;
  logic        sda_oe_q, busy_q, wr_en_q, rd_en_q;
  logic [15:0] wr_addr_q, rd_addr_q;
  logic [7:0]  wr_data_q;

  logic        scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]  rx_byte;
  logic [15:0] ptr_inc;

  // Line events from the synchronised copies; sync regs idle high like the bus.
  assign scl_rise = scl_s2_q & ~scl_d_q;
  assign scl_fall = ~scl_s2_q & scl_d_q;
  assign start_ev = scl_s2_q & sda_d_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & ~sda_d_q & sda_s2_q;
  assign rx_byte  = {shift_q[6:0], sda_s2_q};

  // Pointer increment; in 1-byte mode the upper address byte stays zero.
  always_comb begin
    if (ADDR_BYTES == 1) ptr_inc = {8'h00, ptr_q[7:0] + 8'h01};
    else                 ptr_inc = ptr_q + 16'h0001;
  end

  // Two-stage synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_d_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_d_q <= 1'b1;
    end else begin
      scl_s1_q <= i_scl;    scl_s2_q <= scl_s1_q; scl_d_q <= scl_s2_q;
      sda_s1_q <= i_sda;    sda_s2_q <= sda_s1_q; sda_d_q <= sda_s2_q;
    end
  end

  // Protocol FSM with registered outputs; START/STOP override bit handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      addr_hi_q <= 8'h00;
      abyte_q   <= 2'd0;
      ptr_q     <= 16'h0000;
      rw_q      <= 1'b0;
      cap_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 8'h00;
      rd_addr_q <= 16'h0000;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      if (start_ev) begin
        state_q  <= DEV_ADDR;
        bitcnt_q <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        cap_q    <= 1'b0;
      end else if (stop_ev) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        cap_q    <= 1'b0;
      end else begin
        case (state_q)
          DEV_ADDR: if (scl_rise) begin
            shift_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                rw_q    <= rx_byte[0];
                busy_q  <= 1'b1;
                state_q <= DEV_ACK;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          // ACK states: first SCL fall pulls SDA low, second fall releases it.
          DEV_ACK: if (scl_fall) begin
            if (!sda_oe_q) sda_oe_q <= 1'b1;
            else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= 4'd0;
              if (rw_q) begin
                state_q   <= RDATA;
                rd_en_q   <= 1'b1;
                rd_addr_q <= ptr_q;
                cap_q     <= 1'b1;
              end else begin
                state_q <= REG_ADDR;
                abyte_q <= 2'd0;
              end
            end
          end
          REG_ADDR: if (scl_rise) begin
            shift_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              state_q <= REG_ACK;
              abyte_q <= abyte_q + 2'd1;
              if (abyte_q + 2'd1 == NUM_AB)
                ptr_q <= (ADDR_BYTES == 1) ? {8'h00, rx_byte} : {addr_hi_q, rx_byte};
              else
                addr_hi_q <= rx_byte;
            end
          end
          REG_ACK: if (scl_fall) begin
            if (!sda_oe_q) sda_oe_q <= 1'b1;
            else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= 4'd0;
              state_q  <= (abyte_q == NUM_AB) ? WDATA : REG_ADDR;
            end
          end
          WDATA: if (scl_rise) begin
            shift_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ptr_q;
              wr_data_q <= rx_byte;
              ptr_q     <= ptr_inc;
              state_q   <= WDATA_ACK;
            end
          end
          WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) sda_oe_q <= 1'b1;
            else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= 4'd0;
              state_q  <= WDATA;
            end
          end
          // bitcnt counts bits the master has clocked; fall after bit 8 hands off.
          RDATA: begin
            if (cap_q) begin
              cap_q    <= 1'b0;
              shift_q  <= i_rd_data;
              ptr_q    <= ptr_inc;
              sda_oe_q <= ~i_rd_data[7];
              bitcnt_q <= 4'd0;
            end else if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RDATA_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s2_q) state_q <= WAIT_STOP;
            end else if (scl_fall) begin
              state_q   <= RDATA;
              rd_en_q   <= 1'b1;
              rd_addr_q <= ptr_q;
              cap_q     <= 1'b1;
              bitcnt_q  <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_sda_oe  = sda_oe_q;
  assign o_busy    = busy_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_i2c_slave_module.sv
// Directed bench for i2c_slave_module: bit-banged master, open-drain SDA,
// register-file read model data = addr[7:0] ^ 0xA5.
module tb_i2c_slave_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  logic        sda_oe, wr_en, rd_en, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  wire         sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_module #(.SLAVE_ADDR(7'h5A), .ADDR_BYTES(2)) dut (
    .clk(clk), .rst(rst), .i_scl(scl), .i_sda(sda_line),
    .o_sda_oe(sda_oe), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_busy(busy)
  );

  int checks = 0;
  int failures = 0;
  logic [23:0] wr_log[$];
  logic [15:0] rd_log[$];
  int oe_cnt = 0;
  int busy_cnt = 0;

  // Monitor + register-file model, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (rd_en) begin
      rd_log.push_back(rd_addr);
      rd_data = rd_addr[7:0] ^ 8'hA5;
    end
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [23:0] exp);
    logic [23:0] v;
    v = (idx < wr_log.size()) ? wr_log[idx] : 24'hxxxxxx;
    chk(tag, {8'h00, v}, {8'h00, exp});
  endtask

  task automatic chk_rd(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] v;
    v = (idx < rd_log.size()) ? rd_log[idx] : 16'hxxxx;
    chk(tag, {16'h0, v}, {16'h0, exp});
  endtask

  task automatic qwait;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qwait; scl = 1'b1; qwait; qwait; scl = 1'b0; qwait;
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; qwait; scl = 1'b1; qwait; b = sda_line; qwait; scl = 1'b0; qwait;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; qwait; scl = 1'b1; qwait; m_sda = 1'b0; qwait; scl = 1'b0; qwait;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; qwait; scl = 1'b1; qwait; m_sda = 1'b1; qwait; qwait;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(l);
    ack = ~l;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    logic l;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(l);
      d[i] = l;
    end
    send_bit(nack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    int acks, wb, rb, oe0, bz0;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe", {31'b0, sda_oe}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_rd_en", {31'b0, rd_en}, 32'd0);

    // 1: write 01..04 to 0x0002
    wb = wr_log.size(); acks = 0;
    i2c_start;
    wbyte(8'hB4, a); acks += int'(a);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wbyte(8'h00, a); acks += int'(a);
    wbyte(8'h02, a); acks += int'(a);
    for (int k = 1; k <= 4; k++) begin
      wbyte(8'(k), a); acks += int'(a);
    end
    i2c_stop;
    chk("t1_acks", acks, 7);
    chk("t1_busy_after_stop", {31'b0, busy}, 32'd0);
    chk("t1_nwr", wr_log.size() - wb, 4);
    chk_wr("t1_wr0", wb,     24'h0002_01);
    chk_wr("t1_wr1", wb + 1, 24'h0003_02);
    chk_wr("t1_wr2", wb + 2, 24'h0004_03);
    chk_wr("t1_wr3", wb + 3, 24'h0005_04);

    // 2: wrong device address
    wb = wr_log.size(); rb = rd_log.size(); oe0 = oe_cnt; bz0 = busy_cnt;
    i2c_start;
    wbyte(8'hB6, a);
    chk("t2_nack", {31'b0, a}, 32'd0);
    wbyte(8'h00, a);
    i2c_stop;
    chk("t2_oe_cnt", oe_cnt - oe0, 0);
    chk("t2_nwr", wr_log.size() - wb, 0);
    chk("t2_nrd", rd_log.size() - rb, 0);
    chk("t2_busy_cnt", busy_cnt - bz0, 0);

    // 3: set pointer 0x0010, repeated START, read 3 bytes
    rb = rd_log.size(); acks = 0;
    i2c_start;
    wbyte(8'hB4, a); acks += int'(a);
    wbyte(8'h00, a); acks += int'(a);
    wbyte(8'h10, a); acks += int'(a);
    i2c_start;
    wbyte(8'hB5, a); acks += int'(a);
    chk("t3_acks", acks, 4);
    rbyte(d, 1'b0); chk("t3_d0", {24'b0, d}, 32'hB5);
    rbyte(d, 1'b0); chk("t3_d1", {24'b0, d}, 32'hB4);
    rbyte(d, 1'b1); chk("t3_d2", {24'b0, d}, 32'hB7);
    chk("t3_oe_after_nack", {31'b0, sda_oe}, 32'd0);
    i2c_stop;
    chk("t3_nrd", rd_log.size() - rb, 3);
    chk_rd("t3_rd0", rb,     16'h0010);
    chk_rd("t3_rd1", rb + 1, 16'h0011);
    chk_rd("t3_rd2", rb + 2, 16'h0012);

    // 4: pointer wrap
    wb = wr_log.size();
    i2c_start;
    wbyte(8'hB4, a); wbyte(8'hFF, a); wbyte(8'hFF, a);
    wbyte(8'hAA, a); wbyte(8'hBB, a);
    i2c_stop;
    chk("t4_nwr", wr_log.size() - wb, 2);
    chk_wr("t4_wr0", wb,     24'hFFFF_AA);
    chk_wr("t4_wr1", wb + 1, 24'h0000_BB);

    // 5: STOP inside a data byte, then a normal transaction
    wb = wr_log.size();
    i2c_start;
    wbyte(8'hB4, a); wbyte(8'h00, a); wbyte(8'h20, a);
    wbyte(8'h11, a);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop;
    chk("t5_nwr_partial", wr_log.size() - wb, 1);
    chk_wr("t5_wr0", wb, 24'h0020_11);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    i2c_start;
    wbyte(8'hB4, a); wbyte(8'h00, a); wbyte(8'h30, a);
    wbyte(8'h33, a);
    chk("t5_ack_after", {31'b0, a}, 32'd1);
    i2c_stop;
    chk_wr("t5_wr1", wb + 1, 24'h0030_33);

    // 6: asynchronous reset while the slave drives ACK
    rb = rd_log.size();
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 || i == 4 || i == 2);
    chk("t6_ack_driving", {31'b0, sda_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_oe_async", {31'b0, sda_oe}, 32'd0);
    chk("t6_busy_async", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    i2c_stop;
    i2c_start;
    wbyte(8'hB5, a);
    chk("t6_dev_ack", {31'b0, a}, 32'd1);
    rbyte(d, 1'b1);
    i2c_stop;
    chk("t6_data", {24'b0, d}, 32'hA5);
    chk_rd("t6_rd_addr", rb, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_module.md
Name: i2c_slave_module

Overview:
I2C responder (slave) that answers transactions from the team's I2C master.
- Oversamples SCL/SDA on the system clock.
- Decodes the device address, then a 1- or 2-byte register address.
- Writes: presents each data byte on a single-cycle register-write strobe.
- Reads: fetches bytes through a single-cycle read-request port with 1-cycle data latency.
- Register pointer auto-increments per byte.
- Sits between the I2C pads (open-drain SDA) and a register file or BRAM.

Parameters:
SLAVE_ADDR, 7'h5A, 7-bit device address matched after START.
ADDR_BYTES, 2, register-address length in bytes; legal values 1 or 2. With 1, o_*_addr[15:8] = 0.

Ports:
clk  in  1  system clock; must be >= 8x SCL frequency.
rst  in  1  asynchronous, active-high reset.
i_scl  in  1  SCL pad input; slave never stretches the clock.
i_sda  in  1  SDA pad input.
o_sda_oe  out  1  1 = pull SDA low; 0 = release.
o_wr_en  out  1  single-cycle register-write strobe.
o_wr_addr  out  16  write address, valid with o_wr_en.
o_wr_data  out  8  write data, valid with o_wr_en.
o_rd_en  out  1  single-cycle read request.
o_rd_addr  out  16  read address, valid with o_rd_en.
i_rd_data  in  8  read data, sampled exactly 1 clk after o_rd_en.
o_busy  out  1  high from device-address match until STOP, START or mismatch.

Behaviour:
Reset (asynchronous assert, applies at any time including mid-transfer):
- All outputs = 0, o_sda_oe released.
- Register pointer = 0x0000, FSM = IDLE.

Synchronisation and line events:
- SCL and SDA each pass through a 2-FF synchronizer plus one delay FF for edge detection. Pad-to-event latency is 3 clk.
- START = synced SDA falls while synced SCL high. STOP = synced SDA rises while synced SCL high.
- Data bits are sampled on the SCL rising-edge event, MSB first.
- o_sda_oe changes only on the SCL falling-edge event (or reset).

FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.

IDLE:
- START -> DEV_ADDR with bit counter cleared.
- SCL activity without START is ignored.

DEV_ADDR, after 8 bits:
- addr[7:1] == SLAVE_ADDR -> DEV_ACK; o_busy = 1.
- Mismatch -> WAIT_STOP; SDA is never driven.

DEV_ACK:
- o_sda_oe = 1 from the SCL fall after bit 8 until the SCL fall after bit 9.
- R/W = 0 -> REG_ADDR. R/W = 1 -> RDATA.

REG_ADDR / REG_ACK:
- Receive ADDR_BYTES bytes, MSB byte first, ACKing each one.
- The pointer loads once the final address byte is complete; then -> WDATA.

WDATA / WDATA_ACK:
- After the 8th bit's SCL rise: o_wr_en pulses for 1 clk with o_wr_addr = pointer and o_wr_data = byte. Pointer increments on the same cycle.
- ACK the byte, then -> WDATA for the next byte.

RDATA:
- Entry is the SCL fall that ends the preceding ACK bit. On that same cycle o_rd_en pulses with o_rd_addr = pointer.
- i_rd_data is captured into the shift register the next clk; pointer increments.
- MSB is driven immediately after capture, i.e. well before the next SCL rise.
- Each subsequent bit is driven on an SCL fall: bit = 0 -> o_sda_oe = 1; bit = 1 -> o_sda_oe = 0.

RDATA_ACK:
- SDA is released for bit 9 and the master's response is sampled on the SCL rise.
- Low (ACK) -> fetch the next byte at the following SCL fall.
- High (NACK) -> WAIT_STOP; no further o_rd_en.

WAIT_STOP: SDA released; wait for STOP or START.

Pointer:
- 16-bit, wraps 0xFFFF -> 0x0000.
- Retained across repeated START, so write-address / Sr / read works.
- Not cleared by STOP; only reset clears it.

Line events in any non-IDLE state:
- START -> DEV_ADDR.
- STOP -> IDLE.
- On either: o_sda_oe = 0 immediately and o_busy = 0.
- A partial data byte is discarded and no o_wr_en is issued for it.

Simultaneous events: START/STOP detection takes priority over bit sampling in the same clk.

Test Plan:
1. Write, SLAVE_ADDR = 0x5A, addr 0x0002, data 01 02 03 04, then STOP -> four o_wr_en pulses with (addr, data) = (0002,01), (0003,02), (0004,03), (0005,04); slave ACKs on all 7 bytes; o_busy low after STOP.
2. Device address 0x5B, write -> o_sda_oe never asserted, no o_wr_en/o_rd_en, o_busy stays 0.
3. Write addr 0x0010, Sr, read 3 bytes with master ACK, ACK, NACK; i_rd_data = o_rd_addr[7:0] ^ 0xA5 -> exactly 3 o_rd_en at 0010..0012; bytes B5 B4 B7 on SDA; SDA released after the NACK.
4. Write addr 0xFFFF, data AA BB -> o_wr_en at 0xFFFF (AA) then 0x0000 (BB).
5. STOP after 4 bits of the second data byte -> only the first byte is written; FSM returns to IDLE; the next transaction works normally.
6. Assert rst while the slave is driving an ACK -> o_sda_oe = 0 within the same cycle (asynchronous); after release the pointer reads 0x0000 (read without address returns data for addr 0).
